// File: rtl/sd_sdram_wr_ctrl_if.sv
// SDRAM controller write-burst port: request/address/length out, data pulled
// by the controller with wr_burst_data_req, completion signalled by wr_burst_finish.
interface sd_sdram_wr_ctrl_if #(
  parameter int ADDR_W = 24
);
  logic              wr_burst_req;
  logic [ADDR_W-1:0] wr_burst_addr;
  logic [9:0]        wr_burst_len;
  logic              wr_burst_data_req;
  logic [15:0]       wr_burst_data;
  logic              wr_burst_finish;

  modport master (
    output wr_burst_req,
    output wr_burst_addr,
    output wr_burst_len,
    output wr_burst_data,
    input  wr_burst_data_req,
    input  wr_burst_finish
  );

  modport slave (
    input  wr_burst_req,
    input  wr_burst_addr,
    input  wr_burst_len,
    input  wr_burst_data,
    output wr_burst_data_req,
    output wr_burst_finish
  );
endinterface

// File: rtl/sd_sdram_wr_ctrl.sv
// Buffers SD-reader pixel words in a FWFT FIFO and writes them to the SDRAM
// frame buffer as fixed-length bursts at consecutive addresses.
module sd_sdram_wr_ctrl #(
  parameter int                BURST_LEN   = 256,
  parameter int                FIFO_AW     = 9,
  parameter int                ADDR_W      = 24,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                FRAME_WORDS = 786432
) (
  input  logic                  SD_clk,
  input  logic                  rst,
  input  logic [15:0]           pix_data,
  input  logic                  pix_valid,
  input  logic                  frame_clr,
  sd_sdram_wr_ctrl_if.master    wr_if,
  output logic [FIFO_AW:0]      fifo_level,
  output logic                  frame_done,
  output logic                  overflow
);

  localparam int LW = FIFO_AW + 1;
  localparam int CW = $clog2(BURST_LEN + 1);
  localparam int WW = $clog2(FRAME_WORDS + 1);
  localparam logic [LW-1:0]     DEPTH_LVL  = LW'(1 << FIFO_AW);
  localparam logic [LW-1:0]     BURST_LVL  = LW'(BURST_LEN);
  localparam logic [CW-1:0]     BURST_LAST = CW'(BURST_LEN - 1);
  localparam logic [WW-1:0]     W_BURST    = WW'(BURST_LEN);
  localparam logic [WW-1:0]     W_FRAME    = WW'(FRAME_WORDS);
  localparam logic [ADDR_W-1:0] A_BURST    = ADDR_W'(BURST_LEN);

  typedef enum logic [1:0] {IDLE, REQ, DATA, WAIT_FIN} state_t;

  state_t              state_q, state_d;
  logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]       level_q, level_d;
  logic [CW-1:0]       pop_cnt_q, pop_cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WW-1:0]       word_cnt_q, word_cnt_d;
  logic                frame_done_q, frame_done_d;
  logic                overflow_q, overflow_d;
  logic                clr_pend_q, clr_pend_d;
  logic                push, pop, in_burst, fifo_empty, burst_end;

  logic [15:0] fifo_mem [1 << FIFO_AW];

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    pop_cnt_d    = pop_cnt_q;
    addr_d       = addr_q;
    word_cnt_d   = word_cnt_q;
    frame_done_d = frame_done_q;
    overflow_d   = overflow_q;
    clr_pend_d   = clr_pend_q;
    burst_end    = 1'b0;
    pop          = 1'b0;

    fifo_empty = (level_q == '0);
    in_burst   = (state_q == REQ) || (state_q == DATA);
    // Fullness is judged on the registered level, so a same-cycle pop cannot make room.
    push       = pix_valid && (level_q < DEPTH_LVL);

    if (pix_valid && !push) overflow_d = 1'b1;
    if (in_burst && wr_if.wr_burst_data_req) begin
      if (fifo_empty) overflow_d = 1'b1;
      else            pop        = 1'b1;
    end

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (!push && pop) level_d = level_q - 1'b1;

    case (state_q)
      IDLE: begin
        pop_cnt_d = '0;
        if (frame_clr) begin
          frame_done_d = 1'b0;
          word_cnt_d   = '0;
          addr_d       = BASE_ADDR;
        end
        if ((level_q >= BURST_LVL) && !frame_done_q) state_d = REQ;
      end
      REQ, DATA: begin
        if (frame_clr) clr_pend_d = 1'b1;
        if (pop) begin
          pop_cnt_d = pop_cnt_q + 1'b1;
          state_d   = DATA;
          if (pop_cnt_q == BURST_LAST) begin
            state_d   = WAIT_FIN;
            burst_end = wr_if.wr_burst_finish;
          end
        end
      end
      WAIT_FIN: begin
        if (frame_clr) clr_pend_d = 1'b1;
        burst_end = wr_if.wr_burst_finish;
      end
      default: state_d = IDLE;
    endcase

    // A clear requested during the burst wins over the address/count advance.
    if (burst_end) begin
      state_d = IDLE;
      if (clr_pend_q || frame_clr) begin
        clr_pend_d   = 1'b0;
        frame_done_d = 1'b0;
        word_cnt_d   = '0;
        addr_d       = BASE_ADDR;
      end else begin
        addr_d     = addr_q + A_BURST;
        word_cnt_d = word_cnt_q + W_BURST;
        if (word_cnt_q + W_BURST == W_FRAME) frame_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge SD_clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      pop_cnt_q    <= '0;
      addr_q       <= BASE_ADDR;
      word_cnt_q   <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      clr_pend_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      pop_cnt_q    <= pop_cnt_d;
      addr_q       <= addr_d;
      word_cnt_q   <= word_cnt_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      clr_pend_q   <= clr_pend_d;
    end
  end

  always_ff @(posedge SD_clk) begin
    if (push) fifo_mem[wr_ptr_q] <= pix_data;
  end

  // The request drops combinationally on the controller's first data pull.
  assign wr_if.wr_burst_req  = (state_q == REQ) && !wr_if.wr_burst_data_req;
  assign wr_if.wr_burst_addr = addr_q;
  assign wr_if.wr_burst_len  = 10'(BURST_LEN);
  assign wr_if.wr_burst_data = fifo_empty ? 16'h0000 : fifo_mem[rd_ptr_q];
  assign fifo_level          = level_q;
  assign frame_done          = frame_done_q;
  assign overflow            = overflow_q;

endmodule

// File: tb/tb_sd_sdram_wr_ctrl.sv
// Directed bench for sd_sdram_wr_ctrl; a 4-burst frame keeps the run short.
module tb_sd_sdram_wr_ctrl;

  logic        SD_clk;
  logic        rst;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        frame_clr;
  logic [9:0]  fifo_level;
  logic        frame_done;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  logic [15:0] mq[$];

  sd_sdram_wr_ctrl_if #(.ADDR_W(24)) wr_if ();

  sd_sdram_wr_ctrl #(
    .BURST_LEN(256), .FIFO_AW(9), .ADDR_W(24), .BASE_ADDR(24'd0), .FRAME_WORDS(1024)
  ) dut (
    .SD_clk(SD_clk), .rst(rst), .pix_data(pix_data), .pix_valid(pix_valid),
    .frame_clr(frame_clr), .wr_if(wr_if), .fifo_level(fifo_level),
    .frame_done(frame_done), .overflow(overflow)
  );

  initial SD_clk = 1'b0;
  always #5 SD_clk = ~SD_clk;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge SD_clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    pix_data = '0;
    pix_valid = 1'b0;
    frame_clr = 1'b0;
    wr_if.wr_burst_data_req = 1'b0;
    wr_if.wr_burst_finish = 1'b0;
    mq.delete();
    repeat (3) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic push_words(input int n, input int base, input int gap);
    for (int i = 0; i < n; i++) begin
      pix_valid = 1'b1;
      pix_data = 16'(base + i);
      if (mq.size() < 512) mq.push_back(pix_data);
      tick();
      pix_valid = 1'b0;
      for (int g = 1; g < gap; g++) tick();
    end
  endtask

  // SDRAM controller model: answers a request one cycle later and pulls a full burst.
  task automatic serve_burst(input logic [23:0] exp_addr, input bit push_too, input int push_base,
                             input int clr_at, input bit fin_on_last, input bit extra_req);
    int wait_cnt;
    int bad;
    int first_bad;
    bit room;
    logic [15:0] exp_w;
    logic [15:0] got_w;
    wait_cnt = 0;
    while (wr_if.wr_burst_req !== 1'b1 && wait_cnt < 64) begin
      tick();
      wait_cnt++;
    end
    checks++;
    if (wr_if.wr_burst_req !== 1'b1) begin
      errors++;
      $display("[TB] FAIL burst_req_timeout req=%b expected 1 within 64 cycles", wr_if.wr_burst_req);
      return;
    end
    checks++;
    if (wr_if.wr_burst_addr !== exp_addr || wr_if.wr_burst_len !== 10'd256) begin
      errors++;
      $display("[TB] FAIL burst_addr_len got addr=%0d len=%0d expected addr=%0d len=256",
               wr_if.wr_burst_addr, wr_if.wr_burst_len, exp_addr);
    end
    tick();
    bad = 0;
    first_bad = 0;
    for (int k = 0; k < 256; k++) begin
      wr_if.wr_burst_data_req = 1'b1;
      wr_if.wr_burst_finish = fin_on_last && (k == 255);
      frame_clr = (k == clr_at);
      pix_valid = push_too;
      pix_data = 16'(push_base + k);
      #1;
      if (k == 0) begin
        checks++;
        if (wr_if.wr_burst_req !== 1'b0) begin
          errors++;
          $display("[TB] FAIL req_drop got req=%b expected 0 on first data_req", wr_if.wr_burst_req);
        end
      end
      room = (mq.size() < 512);
      exp_w = 16'h0000;
      if (mq.size() > 0) exp_w = mq.pop_front();
      got_w = wr_if.wr_burst_data;
      if (got_w !== exp_w) begin
        if (bad == 0) first_bad = k;
        bad++;
      end
      if (push_too && room) mq.push_back(pix_data);
      tick();
    end
    wr_if.wr_burst_data_req = 1'b0;
    wr_if.wr_burst_finish = 1'b0;
    frame_clr = 1'b0;
    pix_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL burst_data addr=%0d bad_words=%0d first_bad_index=%0d expected 0 bad words",
               exp_addr, bad, first_bad);
    end
    if (extra_req) begin
      wr_if.wr_burst_data_req = 1'b1;
      tick();
      wr_if.wr_burst_data_req = 1'b0;
      checks++;
      if (fifo_level !== 10'(mq.size()) || overflow !== 1'b0) begin
        errors++;
        $display("[TB] FAIL extra_data_req got level=%0d ovf=%b expected level=%0d ovf=0",
                 fifo_level, overflow, mq.size());
      end
    end
    if (!fin_on_last) begin
      wr_if.wr_burst_finish = 1'b1;
      tick();
      wr_if.wr_burst_finish = 1'b0;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (wr_if.wr_burst_req !== 1'b0 || wr_if.wr_burst_addr !== 24'd0 || fifo_level !== 10'd0 ||
        frame_done !== 1'b0 || overflow !== 1'b0 || wr_if.wr_burst_data !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_state got req=%b addr=%0d level=%0d done=%b ovf=%b data=%h expected all 0",
               wr_if.wr_burst_req, wr_if.wr_burst_addr, fifo_level, frame_done, overflow, wr_if.wr_burst_data);
    end
    checks++;
    if (wr_if.wr_burst_len !== 10'd256) begin
      errors++;
      $display("[TB] FAIL reset_len got %0d expected 256", wr_if.wr_burst_len);
    end
  endtask

  task automatic test_single_burst();
    apply_reset();
    push_words(255, 0, 16);
    pix_valid = 1'b1;
    pix_data = 16'd255;
    mq.push_back(16'd255);
    tick();
    pix_valid = 1'b0;
    checks++;
    if (fifo_level !== 10'd256 || wr_if.wr_burst_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL latency_cycle1 got level=%0d req=%b expected level=256 req=0",
               fifo_level, wr_if.wr_burst_req);
    end
    tick();
    checks++;
    if (wr_if.wr_burst_req !== 1'b1) begin
      errors++;
      $display("[TB] FAIL latency_cycle2 got req=%b expected 1", wr_if.wr_burst_req);
    end
    serve_burst(24'd0, 1'b0, 0, -1, 1'b0, 1'b1);
    checks++;
    if (wr_if.wr_burst_addr !== 24'd256 || fifo_level !== 10'd0 || wr_if.wr_burst_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_after_finish got addr=%0d level=%0d req=%b expected addr=256 level=0 req=0",
               wr_if.wr_burst_addr, fifo_level, wr_if.wr_burst_req);
    end
  endtask

  task automatic test_push_pop_same_cycle();
    apply_reset();
    push_words(300, 1000, 1);
    checks++;
    if (fifo_level !== 10'd300) begin
      errors++;
      $display("[TB] FAIL prefill_level got %0d expected 300", fifo_level);
    end
    serve_burst(24'd0, 1'b1, 2000, -1, 1'b0, 1'b0);
    checks++;
    if (fifo_level !== 10'd300 || wr_if.wr_burst_data !== 16'd1256) begin
      errors++;
      $display("[TB] FAIL push_pop_level got level=%0d head=%0d expected level=300 head=1256",
               fifo_level, wr_if.wr_burst_data);
    end
    serve_burst(24'd256, 1'b0, 0, -1, 1'b0, 1'b0);
    checks++;
    if (fifo_level !== 10'd44 || wr_if.wr_burst_data !== 16'd2212) begin
      errors++;
      $display("[TB] FAIL push_pop_tail got level=%0d head=%0d expected level=44 head=2212",
               fifo_level, wr_if.wr_burst_data);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    push_words(512, 0, 1);
    checks++;
    if (fifo_level !== 10'd512 || overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fill_512 got level=%0d ovf=%b expected level=512 ovf=0", fifo_level, overflow);
    end
    push_words(8, 600, 1);
    checks++;
    if (fifo_level !== 10'd512 || overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overflow_cap got level=%0d ovf=%b expected level=512 ovf=1", fifo_level, overflow);
    end
    serve_burst(24'd0, 1'b0, 0, -1, 1'b0, 1'b0);
    serve_burst(24'd256, 1'b0, 0, -1, 1'b0, 1'b0);
    checks++;
    if (fifo_level !== 10'd0 || overflow !== 1'b1 || wr_if.wr_burst_addr !== 24'd512) begin
      errors++;
      $display("[TB] FAIL overflow_drain got level=%0d ovf=%b addr=%0d expected level=0 ovf=1 addr=512",
               fifo_level, overflow, wr_if.wr_burst_addr);
    end
  endtask

  task automatic test_frame();
    int seen;
    apply_reset();
    for (int s = 0; s < 4; s++) begin
      push_words(256, s * 256, 1);
      serve_burst(24'(s * 256), 1'b0, 0, -1, (s == 2), 1'b0);
      if (s == 2) begin
        checks++;
        if (wr_if.wr_burst_addr !== 24'd768 || frame_done !== 1'b0) begin
          errors++;
          $display("[TB] FAIL finish_on_last_pop got addr=%0d done=%b expected addr=768 done=0",
                   wr_if.wr_burst_addr, frame_done);
        end
      end
    end
    checks++;
    if (frame_done !== 1'b1 || wr_if.wr_burst_addr !== 24'd1024) begin
      errors++;
      $display("[TB] FAIL frame_done got done=%b addr=%0d expected done=1 addr=1024",
               frame_done, wr_if.wr_burst_addr);
    end
    push_words(256, 5000, 1);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (wr_if.wr_burst_req === 1'b1) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("[TB] FAIL no_req_after_frame got %0d req cycles expected 0", seen);
    end
    frame_clr = 1'b1;
    tick();
    frame_clr = 1'b0;
    checks++;
    if (frame_done !== 1'b0 || wr_if.wr_burst_addr !== 24'd0) begin
      errors++;
      $display("[TB] FAIL idle_frame_clr got done=%b addr=%0d expected done=0 addr=0",
               frame_done, wr_if.wr_burst_addr);
    end
    serve_burst(24'd0, 1'b0, 0, -1, 1'b0, 1'b0);
  endtask

  task automatic test_clr_in_data();
    apply_reset();
    push_words(256, 100, 1);
    serve_burst(24'd0, 1'b0, 0, 50, 1'b0, 1'b0);
    checks++;
    if (wr_if.wr_burst_addr !== 24'd0 || frame_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clr_in_data got addr=%0d done=%b expected addr=0 done=0",
               wr_if.wr_burst_addr, frame_done);
    end
    push_words(256, 400, 1);
    serve_burst(24'd0, 1'b0, 0, -1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_burst();
    int wait_cnt;
    apply_reset();
    push_words(256, 0, 1);
    serve_burst(24'd0, 1'b0, 0, -1, 1'b0, 1'b0);
    push_words(256, 300, 1);
    wait_cnt = 0;
    while (wr_if.wr_burst_req !== 1'b1 && wait_cnt < 64) begin
      tick();
      wait_cnt++;
    end
    checks++;
    if (wr_if.wr_burst_req !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_reset_req_timeout req=%b expected 1", wr_if.wr_burst_req);
    end
    tick();
    for (int k = 0; k < 100; k++) begin
      wr_if.wr_burst_data_req = 1'b1;
      tick();
    end
    checks++;
    if (fifo_level !== 10'd156 || wr_if.wr_burst_addr !== 24'd256) begin
      errors++;
      $display("[TB] FAIL pre_reset got level=%0d addr=%0d expected level=156 addr=256",
               fifo_level, wr_if.wr_burst_addr);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (wr_if.wr_burst_req !== 1'b0 || fifo_level !== 10'd0 || wr_if.wr_burst_addr !== 24'd0 ||
        wr_if.wr_burst_data !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL async_reset got req=%b level=%0d addr=%0d data=%h expected 0 0 0 0",
               wr_if.wr_burst_req, fifo_level, wr_if.wr_burst_addr, wr_if.wr_burst_data);
    end
    wr_if.wr_burst_data_req = 1'b0;
    tick();
    rst = 1'b0;
    mq.delete();
    tick();
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_push_pop_same_cycle();
    test_overflow();
    test_frame();
    test_clr_in_data();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
